// File: rtl/zeroriscy_defines.sv
// Shared constants and types for the instruction-memory responder.
package zeroriscy_defines;

   localparam int INSTR_MEM_MAX_LATENCY     = 4;
   localparam int INSTR_MEM_MAX_OUTSTANDING = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] rdata;
   } instr_mem_rsp_t;

endpackage

// File: rtl/zeroriscy_instr_mem_array.sv
// Word-addressed instruction store with registered read data.
module zeroriscy_instr_mem_array #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [31:0]           o_rdata,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [31:0]           i_wdata
);

   logic [31:0] r_mem [2**ADDR_WIDTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/zeroriscy_instr_mem_slave.sv
// Instruction-fetch bus responder: grant, fixed-latency in-order
// responses, outstanding limit and preload port.
module zeroriscy_instr_mem_slave
   import zeroriscy_defines::*;
#(
   parameter int ADDR_WIDTH      = 12,
   parameter int RDATA_LATENCY   = 1,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_req_i,
   input  logic [31:0]           instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [31:0]           instr_rdata_o,
   input  logic                  stall_i,
   input  logic                  load_we_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic [31:0]           load_wdata_i,
   output logic                  busy_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [CW-1:0]  r_outstanding;
   logic           r_head_valid;
   logic [31:0]    r_rdata;
   logic           w_gnt;
   logic [31:0]    w_ram_rdata;
   instr_mem_rsp_t w_head;
   instr_mem_rsp_t w_tail;
   logic           w_unused;

   assign w_gnt = instr_req_i & ~stall_i & ~load_we_i & rst_n
                & (r_outstanding < CW'(MAX_OUTSTANDING));

   assign w_unused = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0]};

   zeroriscy_instr_mem_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk     (clk),
      .i_re    (w_gnt),
      .i_raddr (instr_addr_i[ADDR_WIDTH+1:2]),
      .o_rdata (w_ram_rdata),
      .i_we    (load_we_i),
      .i_waddr (load_addr_i),
      .i_wdata (load_wdata_i)
   );

   // Stage 1 pairs the grant bit with the RAM's registered read data
   always_ff @(posedge clk) begin
      if (!rst_n) r_head_valid <= 1'b0;
      else        r_head_valid <= w_gnt;
   end

   assign w_head = {r_head_valid, w_ram_rdata};

   if (RDATA_LATENCY == 1) begin : g_lat1
      assign w_tail = w_head;
   end else begin : g_latn
      instr_mem_rsp_t r_pipe [RDATA_LATENCY-1];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < RDATA_LATENCY-1; i++)
               r_pipe[i] <= '0;
         end else begin
            r_pipe[0] <= w_head;
            for (int i = 1; i < RDATA_LATENCY-1; i++)
               r_pipe[i] <= r_pipe[i-1];
         end
      end

      assign w_tail = r_pipe[RDATA_LATENCY-2];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)           r_rdata <= '0;
      else if (w_tail.valid) r_rdata <= w_tail.rdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_outstanding <= '0;
      end else begin
         case ({w_gnt, w_tail.valid})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   assign instr_gnt_o    = w_gnt;
   assign instr_rvalid_o = w_tail.valid;
   assign instr_rdata_o  = w_tail.valid ? w_tail.rdata : r_rdata;
   assign busy_o         = |r_outstanding;

   if (RDATA_LATENCY < 1 || RDATA_LATENCY > INSTR_MEM_MAX_LATENCY) begin : g_bad_lat
      $error("RDATA_LATENCY out of range");
   end
   if (MAX_OUTSTANDING < 1 ||
       MAX_OUTSTANDING > INSTR_MEM_MAX_OUTSTANDING) begin : g_bad_outst
      $error("MAX_OUTSTANDING out of range");
   end

   a_rvalid_outst: assert property (@(posedge clk) disable iff (!rst_n)
      instr_rvalid_o |-> (r_outstanding != '0));
   a_gnt_req: assert property (@(posedge clk)
      instr_gnt_o |-> instr_req_i);

endmodule

// File: tb/tb_zeroriscy_instr_mem_slave.sv
// Scoreboard bench: two responders (latency 1/limit 2, latency 3/limit 4).
module tb_zeroriscy_instr_mem_slave;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = '0;
   logic [1:0]  stall = '0;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [1:0]  busy;
   logic [31:0] addr [2];
   logic [31:0] rdata [2];
   logic        load_we = 1'b0;
   logic [11:0] load_addr = '0;
   logic [31:0] load_wdata = '0;

   logic [31:0] mdl_mem [4096];
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   zeroriscy_instr_mem_slave u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(req[0]), .instr_addr_i(addr[0]),
      .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]),
      .instr_rdata_o(rdata[0]), .stall_i(stall[0]),
      .load_we_i(load_we), .load_addr_i(load_addr),
      .load_wdata_i(load_wdata), .busy_o(busy[0])
   );

   zeroriscy_instr_mem_slave #(
      .RDATA_LATENCY(3), .MAX_OUTSTANDING(4)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(req[1]), .instr_addr_i(addr[1]),
      .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]),
      .instr_rdata_o(rdata[1]), .stall_i(stall[1]),
      .load_we_i(load_we), .load_addr_i(load_addr),
      .load_wdata_i(load_wdata), .busy_o(busy[1])
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % 4096);
   endfunction

   // Reference: outstanding = queued responses; each grant returns the
   // word stored at grant time, exactly L cycles later, in order.
   for (genvar d = 0; d < 2; d++) begin : g_mon
      localparam int L = (d == 0) ? 1 : 3;
      localparam int M = (d == 0) ? 2 : 4;
      exp_t q[$];
      logic [31:0] last = '0;

      always @(negedge clk) begin : mon
         logic exp_g;
         logic exp_v;
         exp_t e;
         if (mon_en) begin
            exp_g = req[d] && !stall[d] && !load_we
                    && (q.size() < M) && rst_n;
            chk($sformatf("gnt%0d", d), {31'b0, gnt[d]}, {31'b0, exp_g});
            chk($sformatf("busy%0d", d), {31'b0, busy[d]},
                {31'b0, q.size() != 0});
            exp_v = (q.size() != 0) && (q[0].due == cyc);
            chk($sformatf("rvalid%0d", d), {31'b0, rvalid[d]},
                {31'b0, exp_v});
            if (exp_v) begin
               e = q.pop_front();
               last = e.data;
            end
            chk($sformatf("rdata%0d", d), rdata[d], last);
            if (exp_g) begin
               e.due = cyc + L;
               e.data = mdl_mem[widx(addr[d])];
               q.push_back(e);
            end
            if (!rst_n) begin
               q.delete();
               last = '0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [31:0] dat);
      load_we = 1'b1;
      load_addr = 12'(a);
      load_wdata = dat;
      mdl_mem[a] = dat;
      tick();
      load_we = 1'b0;
   endtask

   task automatic issue(input int d, input logic [31:0] a);
      logic g;
      g = 1'b0;
      req[d] = 1'b1;
      addr[d] = a;
      for (int i = 0; i < 100 && !g; i++) begin
         @(negedge clk);
         g = gnt[d];
         tick();
      end
      if (!g) chk("grant timeout", {31'b0, g}, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rnd_fetch(input int d, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            a = ($urandom & 32'hFFFF_C000)
              | (32'($urandom_range(0, 63)) << 2)
              | ($urandom & 32'h3);
            issue(d, a);
         end else begin
            req[d] = 1'b0;
            tick();
         end
      end
      req[d] = 1'b0;
   endtask

   task automatic rnd_stall(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         stall[d] = ($urandom_range(0, 3) == 0);
         tick();
      end
      stall[d] = 1'b0;
   endtask

   task automatic rnd_load(input int n);
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(2, 8));
         load($urandom_range(0, 63), $urandom);
      end
   endtask

   initial begin
      addr[0] = '0;
      addr[1] = '0;
      idle(3);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset rvalid", {31'b0, rvalid[d]}, 32'd0);
         chk("reset rdata", rdata[d], 32'd0);
         chk("reset busy", {31'b0, busy[d]}, 32'd0);
      end
      tick();

      for (int i = 0; i < 64; i++) load(i, $urandom);
      load(0, 32'h0000_0013);
      load(1, 32'h0010_0093);
      load(2, 32'h0020_0113);

      issue(0, 32'h0);
      issue(0, 32'h4);
      issue(0, 32'h8);
      req[0] = 1'b0;
      idle(4);

      stall[0] = 1'b1;
      req[0] = 1'b1;
      addr[0] = 32'h4;
      idle(3);
      stall[0] = 1'b0;
      issue(0, 32'h4);
      req[0] = 1'b0;
      idle(3);

      for (int i = 0; i < 4; i++) issue(1, 32'(i) << 2);
      req[1] = 1'b0;
      idle(6);

      req[0] = 1'b1;
      addr[0] = 32'h14;
      load(5, 32'hDEAD_BEEF);
      issue(0, 32'h14);
      req[0] = 1'b0;
      idle(3);

      issue(0, 32'h0000_4008);
      req[0] = 1'b0;
      idle(3);

      issue(1, 32'h4);
      issue(1, 32'h8);
      issue(0, 32'h8);
      req = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle(6);
      issue(0, 32'h0);
      req[0] = 1'b0;
      issue(1, 32'h0);
      req[1] = 1'b0;
      idle(5);

      fork
         rnd_fetch(0, 300);
         rnd_fetch(1, 300);
         rnd_stall(0, 350);
         rnd_stall(1, 350);
         rnd_load(40);
      join
      req = '0;
      stall = '0;
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
